// File: rtl/dircc_node_inbox_writer.sv
// Inbox writer: packs network flits into a ring of fixed-size slots in processing memory port 2
// and commits a {TRUNC, ERR, len} header per packet. DIRCC_INBOX_DROP_CNT_EN enables drop_count.
module dircc_node_inbox_writer #(
  parameter int                ADDR_W     = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 15'h4000,
  parameter int                SLOT_LOG2  = 6,
  parameter int                NSLOT_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     address2,
  output logic [15:0]           writedata2,
  output logic [1:0]            byteenable2,
  output logic                  chipselect2,
  output logic                  write2,
  output logic                  clken2,
  // "release" is a reserved word, hence the suffix on the Nios consume pulse
  input  logic                  release_i,
  output logic [NSLOT_LOG2-1:0] rd_slot,
  output logic [NSLOT_LOG2:0]   slot_count,
  output logic                  irq,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_HDR} state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    write2_q, write2_d;
  logic [ADDR_W-1:0]       address2_q, address2_d;
  logic [15:0]             writedata2_q, writedata2_d;
  logic [NSLOT_LOG2-1:0]   rd_slot_q, rd_slot_d;
  logic [NSLOT_LOG2-1:0]   wr_slot_q, wr_slot_d;
  logic [NSLOT_LOG2:0]     slot_count_q, slot_count_d;
  logic                    irq_q, irq_d;
  logic [SLOT_LOG2-1:0]    len_q, len_d;
  logic                    trunc_q, trunc_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    commit;
  logic                    release_ok;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [NSLOT_LOG2-1:0] s,
                                                  input logic [SLOT_LOG2-1:0]  w);
    return BASE_ADDR + ADDR_W'({s, w});
  endfunction

  assign accept     = in_valid & in_ready_q;
  assign release_ok = release_i && (slot_count_q != '0);

  always_comb begin
    state_d      = state_q;
    write2_d     = 1'b0;
    address2_d   = address2_q;
    writedata2_d = writedata2_q;
    wr_slot_d    = wr_slot_q;
    rd_slot_d    = rd_slot_q;
    len_d        = len_q;
    trunc_d      = trunc_q;
    err_d        = err_q;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && in_sop) begin
          write2_d     = 1'b1;
          address2_d   = slot_addr(wr_slot_q, SLOT_LOG2'(1));
          writedata2_d = in_data;
          len_d        = SLOT_LOG2'(1);
          state_d      = in_eop ? S_HDR : S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          if (in_sop) err_d = 1'b1;
          // len all-ones means the slot payload area is already full
          if (!(&len_q)) begin
            write2_d     = 1'b1;
            address2_d   = slot_addr(wr_slot_q, len_q + 1'b1);
            writedata2_d = in_data;
            len_d        = len_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (in_eop) state_d = S_HDR;
        end
      end
      S_HDR: begin
        write2_d     = 1'b1;
        address2_d   = slot_addr(wr_slot_q, '0);
        writedata2_d = {trunc_q, err_q, 4'b0, 10'(len_q)};
        wr_slot_d    = wr_slot_q + 1'b1;
        commit       = 1'b1;
        len_d        = '0;
        trunc_d      = 1'b0;
        err_d        = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (release_ok) rd_slot_d = rd_slot_q + 1'b1;

    slot_count_d = slot_count_q;
    if (commit && !release_ok)      slot_count_d = slot_count_q + 1'b1;
    else if (!commit && release_ok) slot_count_d = slot_count_q - 1'b1;

    irq_d = (slot_count_d != '0);
    // MSB of the count is set only when every slot is occupied
    in_ready_d = (state_d == S_IDLE) ? ~slot_count_d[NSLOT_LOG2] : (state_d == S_RECV);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      write2_q     <= 1'b0;
      address2_q   <= '0;
      writedata2_q <= '0;
      rd_slot_q    <= '0;
      wr_slot_q    <= '0;
      slot_count_q <= '0;
      irq_q        <= 1'b0;
      len_q        <= '0;
      trunc_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      write2_q     <= write2_d;
      address2_q   <= address2_d;
      writedata2_q <= writedata2_d;
      rd_slot_q    <= rd_slot_d;
      wr_slot_q    <= wr_slot_d;
      slot_count_q <= slot_count_d;
      irq_q        <= irq_d;
      len_q        <= len_d;
      trunc_q      <= trunc_d;
      err_q        <= err_d;
    end
  end

`ifdef DIRCC_INBOX_DROP_CNT_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic        drop_inc;

  // stray non-sop flit in IDLE, or a truncated packet being committed
  assign drop_inc = ((state_q == S_IDLE) && accept && !in_sop) || ((state_q == S_HDR) && trunc_q);

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_inc && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) drop_count_q <= '0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'h0;
`endif

  assign in_ready    = in_ready_q;
  assign address2    = address2_q;
  assign writedata2  = writedata2_q;
  assign write2      = write2_q;
  assign chipselect2 = write2_q;
  assign byteenable2 = 2'b11;
  assign clken2      = 1'b1;
  assign rd_slot     = rd_slot_q;
  assign slot_count  = slot_count_q;
  assign irq         = irq_q;

endmodule
